axis_lfsr_source: RTL and testbench
===================================

Name: axis_lfsr_source

Overview:
- AXI-Stream pseudo-random data source; sits directly upstream of the team's AXI-Stream FIFO and drives its slave port.
- Galois LFSR, advanced once per accepted beat; output framed into packets with tlast.
- Software-style control: seed load, start, graceful stop, packet count, done pulse.

Parameters:
- DATA_WIDTH, 32, tdata width; must be <= LFSR_WIDTH.
- LFSR_WIDTH, 32, LFSR state width.
- POLY, 32'h80200003, Galois tap mask (x^32+x^22+x^2+x+1).
- DEFAULT_SEED, 32'h00000001, reset seed; must be nonzero.
- LEN_WIDTH, 16, width of the packet-length and packet-count fields.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- cfg_seed  in  LFSR_WIDTH  seed value.
- cfg_seed_load  in  1  pulse; loads cfg_seed into the LFSR (IDLE only).
- cfg_pkt_len  in  LEN_WIDTH  beats per packet; 0 treated as 1.
- cfg_num_pkts  in  LEN_WIDTH  packets per run; 0 = run until stop.
- start  in  1  pulse; begins a run (IDLE only).
- stop  in  1  pulse; finish the current packet, then go IDLE.
- m_axis_tdata  out  DATA_WIDTH  LFSR state bits [DATA_WIDTH-1:0].
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of packet.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse at run completion.

Behaviour:
- Reset (async, immediate): state=IDLE, lfsr=DEFAULT_SEED, tvalid=0, tlast=0, tdata=0, busy=0, done=0, all counters 0. Reset mid-packet aborts the packet; no tlast is issued.
- LFSR step: next = (s >> 1) ^ (s[0] ? POLY : 0). Advances only on a handshake (tvalid && tready).
- Seed load in IDLE: lfsr <= cfg_seed, or DEFAULT_SEED if cfg_seed==0 (prevents lockup). Ignored outside IDLE.
- start sampling: cfg_pkt_len and cfg_num_pkts are latched when start is accepted. Later changes have no effect until the next run.
- IDLE: tvalid=0. start -> RUN. tvalid=1 on the next cycle, with tdata equal to the current LFSR state (the first beat is the seed).
- RUN:
  - tvalid held high. tdata and tlast are stable while tvalid && !tready.
  - beat_cnt increments per handshake. tlast=1 when beat_cnt == len-1. On a tlast handshake: beat_cnt<=0, pkt_cnt++.
  - On a tlast handshake where pkt_cnt+1 == num_pkts (num_pkts != 0), or a stop is pending: go IDLE, tvalid=0 on the next cycle, done=1 for one cycle.
- stop:
  - In RUN, sets a sticky stop_pend; the run ends at the next tlast handshake.
  - stop coincident with a tlast handshake ends the run on that beat.
  - stop in IDLE is ignored.
- start while busy is ignored. start and stop in the same cycle from IDLE: run starts with stop_pend set, so exactly one packet is sent.
- The LFSR is not reseeded between packets or runs; a new run continues the sequence unless a seed load occurs.
- Back-pressure: tready=0 for any duration loses and repeats no beats. No combinational path from tready to tvalid or tdata.
- Counters wrap naturally at 2^LEN_WIDTH. num_pkts=0 never terminates by count.
- Throughput: one beat per cycle when tready is held high.

Optional Feature:
- Macro: AXIS_LFSR_ERR_INJ_EN.
- Defined:
  - Adds input err_inject (1 bit).
  - A pulse arms a sticky flag. The next beat presented after arming has tdata[0] inverted; the flag clears on that beat's handshake.
  - LFSR state is unaffected, so later beats are correct. Used to verify downstream checkers.
- Undefined: port absent, no inversion logic.

Test Plan:
- Reset, start, pkt_len=4, num_pkts=1, tready=1 -> tdata 0x00000001, 0x80200003, 0xC0300002, 0x60180001; tlast on beat 4; done pulses one cycle after the final handshake; busy falls.
- Seed load 0x00000000, then start -> first beat is 0x00000001 (DEFAULT_SEED substituted).
- pkt_len=3, num_pkts=2, tready toggling 1/0 every cycle -> exactly 6 beats in the sequence above; tlast on beats 3 and 6; tdata holds during stalls.
- num_pkts=0, pkt_len=5, stop pulsed during beat 2 of packet 3 -> packet 3 completes with tlast on beat 15; then tvalid=0 and done pulses.
- Assert aresetn low while tvalid=1 mid-packet -> tvalid=0 immediately; after release, a start emits 0x00000001 first.
- AXIS_LFSR_ERR_INJ_EN defined: err_inject pulsed before beat 2 -> beat 2 = 0x80200002; beat 3 = 0xC0300002 (unaltered).

Source files
------------

// File: rtl/axis_lfsr_source.sv
// ---------------------------------------------------------------------------
// axis_lfsr_source
//   AXI-Stream pseudo-random data source. A Galois LFSR supplies tdata and
//   advances once per accepted beat. Beats are framed into packets of
//   cfg_pkt_len beats with tlast on the final beat. A run is begun by start
//   and ends after cfg_num_pkts packets, or at the end of the current packet
//   after a stop pulse. done pulses for one cycle when a run completes.
//
//   Optional feature (macro AXIS_LFSR_ERR_INJ_EN): adds input err_inject.
//   A pulse arms a one-shot inversion of tdata[0] on the next presented beat.
//   The LFSR itself is not disturbed, so the following beats are unaltered.
//
// Ports
//   aclk, aresetn      clock, asynchronous active-low reset
//   cfg_seed           seed value (0 maps to DEFAULT_SEED)
//   cfg_seed_load      pulse, load cfg_seed into the LFSR (IDLE only)
//   cfg_pkt_len        beats per packet (0 behaves as 1), latched on start
//   cfg_num_pkts       packets per run (0 = until stop), latched on start
//   start, stop        run control pulses
//   m_axis_*           AXI-Stream master (tdata, tvalid, tready, tlast)
//   busy               high while a run is active
//   done               one-cycle pulse when a run completes
//   err_inject         (AXIS_LFSR_ERR_INJ_EN only) arm a tdata[0] flip
// ---------------------------------------------------------------------------
module axis_lfsr_source #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    LFSR_WIDTH   = 32,
    parameter logic [LFSR_WIDTH-1:0] POLY         = 32'h80200003,
    parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 32'h00000001,
    parameter int                    LEN_WIDTH    = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
`ifdef AXIS_LFSR_ERR_INJ_EN
    input  logic                  err_inject,
`endif
    input  logic [LFSR_WIDTH-1:0] cfg_seed,
    input  logic                  cfg_seed_load,
    input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
    input  logic [LEN_WIDTH-1:0]  cfg_num_pkts,
    input  logic                  start,
    input  logic                  stop,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    logic [0:0]            state;
    logic [LFSR_WIDTH-1:0] lfsr;
    logic [LFSR_WIDTH-1:0] lfsr_next;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [LEN_WIDTH-1:0]  pkt_cnt;
    logic [LEN_WIDTH-1:0]  pkt_cnt_inc;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  num_q;
    logic                  stop_pend;
    logic                  tvalid;
    logic                  hs;
    logic                  last_beat;
    logic                  end_run;

    // Galois step: shift right, fold taps in when the bit shifted out is 1.
    assign lfsr_next   = (lfsr >> 1) ^ (lfsr[0] ? POLY : '0);

    assign hs          = tvalid & m_axis_tready;
    // len_q is never 0 (0 is mapped to 1 when latched), so len_q-1 is safe.
    assign last_beat   = (beat_cnt == (len_q - LEN_ONE));
    assign pkt_cnt_inc = pkt_cnt + LEN_ONE;
    // Evaluated only on a tlast handshake. A stop arriving on that very beat
    // ends the run there rather than one packet later.
    assign end_run     = ((num_q != '0) && (pkt_cnt_inc == num_q)) || stop_pend || stop;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            lfsr      <= DEFAULT_SEED;
            beat_cnt  <= '0;
            pkt_cnt   <= '0;
            len_q     <= '0;
            num_q     <= '0;
            stop_pend <= 1'b0;
            tvalid    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_seed_load)
                        lfsr <= (cfg_seed == '0) ? DEFAULT_SEED : cfg_seed;
                    if (start) begin
                        state     <= ST_RUN;
                        tvalid    <= 1'b1;
                        len_q     <= (cfg_pkt_len == '0) ? LEN_ONE : cfg_pkt_len;
                        num_q     <= cfg_num_pkts;
                        // start+stop together: run exactly one packet
                        stop_pend <= stop;
                        beat_cnt  <= '0;
                        pkt_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (stop)
                        stop_pend <= 1'b1;
                    if (hs) begin
                        lfsr <= lfsr_next;
                        if (last_beat) begin
                            beat_cnt <= '0;
                            pkt_cnt  <= pkt_cnt_inc;
                            if (end_run) begin
                                state     <= ST_IDLE;
                                tvalid    <= 1'b0;
                                done      <= 1'b1;
                                stop_pend <= 1'b0;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + LEN_ONE;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    tvalid <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXIS_LFSR_ERR_INJ_EN
    // inj_arm holds a request until a new beat is about to be presented;
    // inj_act then marks that beat so its tdata stays stable through stalls.
    logic inj_arm;
    logic inj_act;
    logic load_beat;

    assign load_beat = ((state == ST_IDLE) && start) || (hs && !(last_beat && end_run));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            inj_arm <= 1'b0;
            inj_act <= 1'b0;
        end else if (load_beat) begin
            inj_act <= inj_arm | err_inject;
            inj_arm <= 1'b0;
        end else begin
            if (hs)
                inj_act <= 1'b0;
            if (err_inject)
                inj_arm <= 1'b1;
        end
    end

    assign m_axis_tdata = tvalid ? (lfsr[DATA_WIDTH-1:0] ^ DATA_WIDTH'(inj_act)) : '0;
`else
    assign m_axis_tdata = tvalid ? lfsr[DATA_WIDTH-1:0] : '0;
`endif

    assign m_axis_tvalid = tvalid;
    assign m_axis_tlast  = tvalid & last_beat;
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_axis_lfsr_source.sv
// ---------------------------------------------------------------------------
// tb_axis_lfsr_source
//   Directed bench for axis_lfsr_source. Drives runs with various packet
//   lengths, counts, stalls, stop and reset, and compares every accepted beat
//   against hand-derived LFSR values. Build with +define+AXIS_LFSR_ERR_INJ_EN
//   to also exercise the error-injection port.
// ---------------------------------------------------------------------------
module tb_axis_lfsr_source;

    logic        aclk;
    logic        aresetn;
    logic [31:0] cfg_seed;
    logic        cfg_seed_load;
    logic [15:0] cfg_pkt_len;
    logic [15:0] cfg_num_pkts;
    logic        start;
    logic        stop;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;
`ifdef AXIS_LFSR_ERR_INJ_EN
    logic        err_inject;
`endif

    axis_lfsr_source dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
`ifdef AXIS_LFSR_ERR_INJ_EN
        .err_inject    (err_inject),
`endif
        .cfg_seed      (cfg_seed),
        .cfg_seed_load (cfg_seed_load),
        .cfg_pkt_len   (cfg_pkt_len),
        .cfg_num_pkts  (cfg_num_pkts),
        .start         (start),
        .stop          (stop),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected sequence from seed 1: x^32+x^22+x^2+x+1 Galois form.
    logic [31:0] seq [0:31];
    function automatic logic [31:0] step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    logic [31:0] cap_data [$];
    logic        cap_last [$];
    int          last_hs_cyc;
    int          done_cyc;
    int          done_cnt;

    task automatic seed_load(input logic [31:0] v);
        cfg_seed      = v;
        cfg_seed_load = 1'b1;
        @(posedge aclk); #1;
        cfg_seed_load = 1'b0;
    endtask

    // Issue start, then accept beats until done (or the cycle budget runs out).
    task automatic run_capture(input int len, input int num, input bit toggle,
                               input bit stop_start, input int stop_at,
                               input int inj_at, input int max_cyc);
        bit          prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        int          nb;
        cap_data.delete();
        cap_last.delete();
        last_hs_cyc  = -1;
        done_cyc     = -1;
        done_cnt     = 0;
        prev_stall   = 1'b0;
        prev_data    = '0;
        prev_last    = 1'b0;
        nb           = 0;
        cfg_pkt_len  = 16'(len);
        cfg_num_pkts = 16'(num);
        start        = 1'b1;
        stop         = stop_start;
        @(posedge aclk); #1;
        start        = 1'b0;
        stop         = 1'b0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_stall) begin
                chk("stall_hold_data", m_axis_tdata, prev_data);
                chk("stall_hold_last", 32'(m_axis_tlast), 32'(prev_last));
            end
            m_axis_tready = toggle ? (cyc % 2 == 0) : 1'b1;
            stop = 1'b0;
`ifdef AXIS_LFSR_ERR_INJ_EN
            err_inject = 1'b0;
`endif
            if (m_axis_tvalid && m_axis_tready) begin
                cap_data.push_back(m_axis_tdata);
                cap_last.push_back(m_axis_tlast);
                nb++;
                last_hs_cyc = cyc;
                if (nb == stop_at) stop = 1'b1;
`ifdef AXIS_LFSR_ERR_INJ_EN
                if (nb == inj_at) err_inject = 1'b1;
`endif
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (done_cnt > 0 && cyc > done_cyc + 2) break;
            @(posedge aclk); #1;
        end
        stop = 1'b0;
`ifdef AXIS_LFSR_ERR_INJ_EN
        err_inject = 1'b0;
`endif
        if (inj_at < 0) begin end
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("done_after_last_hs", 32'(done_cyc), 32'(last_hs_cyc + 1));
        chk("end_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
    endtask

    // Compare captured beats to seq[0..n-1], tlast every len beats.
    task automatic check_beats(input string tag, input int n, input int len);
        chk({tag, "_nbeats"}, 32'(cap_data.size()), 32'(n));
        for (int i = 0; i < n && i < cap_data.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i + 1), cap_data[i], seq[i]);
            chk($sformatf("%s_last%0d", tag, i + 1), 32'(cap_last[i]),
                32'(((i + 1) % len) == 0));
        end
    endtask

    initial begin
        aresetn       = 1'b0;
        cfg_seed      = '0;
        cfg_seed_load = 1'b0;
        cfg_pkt_len   = '0;
        cfg_num_pkts  = '0;
        start         = 1'b0;
        stop          = 1'b0;
        m_axis_tready = 1'b1;
`ifdef AXIS_LFSR_ERR_INJ_EN
        err_inject    = 1'b0;
`endif
        seq[0] = 32'h00000001;
        for (int i = 1; i < 32; i++) seq[i] = step(seq[i-1]);

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tlast",  32'(m_axis_tlast),  32'd0);
        chk("rst_tdata",  m_axis_tdata,       32'd0);
        chk("rst_busy",   32'(busy),          32'd0);
        chk("rst_done",   32'(done),          32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // One packet of 4 from the default seed, hand-computed values.
        run_capture(4, 1, 1'b0, 1'b0, 0, 0, 40);
        chk("t1_nbeats", 32'(cap_data.size()), 32'd4);
        if (cap_data.size() == 4) begin
            chk("t1_d1", cap_data[0], 32'h00000001);
            chk("t1_d2", cap_data[1], 32'h80200003);
            chk("t1_d3", cap_data[2], 32'hC0300002);
            chk("t1_d4", cap_data[3], 32'h60180001);
            chk("t1_l3", 32'(cap_last[2]), 32'd0);
            chk("t1_l4", 32'(cap_last[3]), 32'd1);
        end

        // Zero seed substitutes DEFAULT_SEED; 2 packets of 3 with stalls.
        seed_load(32'h0);
        run_capture(3, 2, 1'b1, 1'b0, 0, 0, 60);
        check_beats("t3", 6, 3);

        // Run-forever, stop during beat 2 of packet 3 -> ends at beat 15.
        seed_load(32'h1);
        run_capture(5, 0, 1'b0, 1'b0, 12, 0, 80);
        check_beats("t4", 15, 5);

        // pkt_len 0 behaves as 1: two single-beat packets.
        seed_load(32'h1);
        run_capture(0, 2, 1'b0, 1'b0, 0, 0, 40);
        check_beats("t_len0", 2, 1);

        // Reset mid-packet, then start+stop together -> exactly one packet.
        seed_load(32'h12345678);
        cfg_pkt_len   = 16'd8;
        cfg_num_pkts  = 16'd0;
        m_axis_tready = 1'b1;
        start         = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        chk("t5_first_seeded", m_axis_tdata, 32'h12345678);
        @(posedge aclk); #1;
        chk("t5_pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("t5_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t5_rst_tdata",  m_axis_tdata,       32'd0);
        chk("t5_rst_busy",   32'(busy),          32'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        run_capture(2, 0, 1'b0, 1'b1, 0, 0, 40);
        check_beats("t5", 2, 2);

`ifdef AXIS_LFSR_ERR_INJ_EN
        // Flip bit 0 of beat 2 only.
        seed_load(32'h1);
        run_capture(3, 1, 1'b0, 1'b0, 0, 1, 40);
        chk("t6_nbeats", 32'(cap_data.size()), 32'd3);
        if (cap_data.size() == 3) begin
            chk("t6_d1", cap_data[0], 32'h00000001);
            chk("t6_d2", cap_data[1], 32'h80200002);
            chk("t6_d3", cap_data[2], 32'hC0300002);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
